// File: rtl/ws2812_frame_buffer_pkg.sv
// Shared definitions for the WS2812 frame buffer: SFR offsets, FSM encoding,
// GRB field positions and the brightness scaling helper.
package ws2812_frame_buffer_pkg;

  localparam logic [7:0] OFF_IDX  = 8'd0;
  localparam logic [7:0] OFF_G    = 8'd1;
  localparam logic [7:0] OFF_R    = 8'd2;
  localparam logic [7:0] OFF_B    = 8'd3;
  localparam logic [7:0] OFF_LEN  = 8'd4;
  localparam logic [7:0] OFF_CTRL = 8'd5;
  localparam logic [7:0] OFF_BRI  = 8'd6;

  localparam int CTRL_SHOW_BIT = 0;
  localparam int CTRL_CLR_BIT  = 1;

  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int R_MSB = 15;
  localparam int R_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SCALE = 2'd2,
    ST_SEND  = 2'd3
  } state_e;

  // (c * (bri + 1)) >> 8, so bri = 8'hFF passes the channel through unchanged
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] bri);
    logic [16:0] prod;
    prod = {9'd0, c} * ({9'd0, bri} + 17'd1);
    return prod[15:8];
  endfunction

  function automatic logic [23:0] scale_grb(input logic [23:0] grb, input logic [7:0] bri);
    logic [23:0] res;
    res = 24'd0;
    res[G_MSB:G_LSB] = scale_ch(grb[G_MSB:G_LSB], bri);
    res[R_MSB:R_LSB] = scale_ch(grb[R_MSB:R_LSB], bri);
    res[B_MSB:B_LSB] = scale_ch(grb[B_MSB:B_LSB], bri);
    return res;
  endfunction

endpackage

// File: rtl/ws2812_frame_buffer_if.sv
// SFR write bus plus the pixel valid/ready stream towards the serializer.
// The frame buffer uses the slave modport; CPU/serializer side uses master.
interface ws2812_frame_buffer_if;
  logic [7:0]  sfr_addr;
  logic [7:0]  controller_data_in;
  logic        sfr_wr;
  logic [23:0] pix_grb;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;
  logic        busy;

  modport slave (
    input  sfr_addr, controller_data_in, sfr_wr, pix_ready,
    output pix_grb, pix_valid, pix_last, busy
  );

  modport master (
    output sfr_addr, controller_data_in, sfr_wr, pix_ready,
    input  pix_grb, pix_valid, pix_last, busy
  );
endinterface

// File: rtl/ws2812_pix_dpram.sv
// Simple dual-port pixel RAM holding both buffers; the address MSB selects
// the buffer. Read data is registered (1-cycle latency), contents are not reset.
module ws2812_pix_dpram #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // CPU write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; output register cleared so no stale pixel survives reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ws2812_frame_buffer.sv
// Double-buffered WS2812 pixel store: CPU fills the back buffer over SFRs, SHOW
// swaps and streams the front buffer pixel by pixel. Optional BRIGHTNESS_EN scaling.
module ws2812_frame_buffer
  import ws2812_frame_buffer_pkg::*;
#(
  parameter int         MAX_LED  = 64,
  parameter logic [7:0] SFR_BASE = 8'hC6
) (
  input logic                  clk,
  input logic                  rst,
  ws2812_frame_buffer_if.slave bus
);

  localparam int IW = $clog2(MAX_LED);
  localparam int LW = $clog2(MAX_LED + 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(MAX_LED - 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LED);

  logic [7:0]    off_s;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    g_q, g_d, r_q, r_d, len_q, len_d;
  logic          show_s, commit_s;
  logic [23:0]   wdata_s;
  logic [LW-1:0] len_eff_s;

  state_e        state_q, state_d;
  logic [IW-1:0] rd_ptr_q, rd_ptr_d;
  logic          front_q, front_d;
  logic          show_pend_q, show_pend_d, pend_eff_s;
  logic          pix_valid_q, pix_valid_d, pix_last_q, pix_last_d, busy_q, busy_d;
  logic          accept_s, ram_re_s;
  logic [23:0]   ram_rdata_s;

`ifdef BRIGHTNESS_EN
  logic [7:0]    bri_q, bri_d;
  logic [23:0]   pix_q;
`endif

  assign off_s = bus.sfr_addr - SFR_BASE;

  // SFR decode and CPU-side next state
  always_comb begin
    idx_d    = idx_q;
    g_d      = g_q;
    r_d      = r_q;
    len_d    = len_q;
    show_s   = 1'b0;
    commit_s = 1'b0;
`ifdef BRIGHTNESS_EN
    bri_d    = bri_q;
`endif
    if (bus.sfr_wr) begin
      case (off_s)
        OFF_IDX:  idx_d = bus.controller_data_in[IW-1:0];
        OFF_G:    g_d   = bus.controller_data_in;
        OFF_R:    r_d   = bus.controller_data_in;
        OFF_B: begin
          commit_s = 1'b1;
          idx_d    = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
        OFF_LEN:  len_d = bus.controller_data_in;
        OFF_CTRL: begin
          show_s = bus.controller_data_in[CTRL_SHOW_BIT];
          if (bus.controller_data_in[CTRL_CLR_BIT]) begin
            idx_d = '0;
          end else begin
            idx_d = idx_q;
          end
        end
`ifdef BRIGHTNESS_EN
        OFF_BRI:  bri_d = bus.controller_data_in;
`else
        OFF_BRI:  begin end
`endif
        default:  begin end
      endcase
    end else begin
      commit_s = 1'b0;
    end
  end

  // Committed pixel is {G,R,B} with B taken straight from the bus
  always_comb begin
    wdata_s = 24'd0;
    wdata_s[G_MSB:G_LSB] = g_q;
    wdata_s[R_MSB:R_LSB] = r_q;
    wdata_s[B_MSB:B_LSB] = bus.controller_data_in;
  end

  // Effective frame length: 0 and anything beyond MAX_LED mean a full buffer
  always_comb begin
    if (len_q == 8'd0 || len_q > 8'(MAX_LED)) begin
      len_eff_s = LEN_MAX;
    end else begin
      len_eff_s = len_q[LW-1:0];
    end
  end

  // CPU-side registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      g_q   <= 8'd0;
      r_q   <= 8'd0;
      len_q <= 8'd0;
    end else begin
      idx_q <= idx_d;
      g_q   <= g_d;
      r_q   <= r_d;
      len_q <= len_d;
    end
  end

`ifdef BRIGHTNESS_EN
  // Brightness register and scaled pixel holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bri_q <= 8'hFF;
      pix_q <= 24'd0;
    end else begin
      bri_q <= bri_d;
      if (state_q == ST_SCALE) begin
        pix_q <= scale_grb(ram_rdata_s, bri_q);
      end else begin
        pix_q <= pix_q;
      end
    end
  end
  assign bus.pix_grb = pix_q;
`else
  assign bus.pix_grb = ram_rdata_s;
`endif

  assign accept_s   = (state_q == ST_SEND) && bus.pix_ready;
  // A SHOW landing in the same cycle as the last accept still counts as pending
  assign pend_eff_s = show_pend_q | show_s;

  // Stream FSM next state and registered output next values
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    front_d     = front_q;
    show_pend_d = show_pend_q;
    ram_re_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (show_s) begin
          front_d  = ~front_q;
          rd_ptr_d = '0;
          state_d  = ST_LOAD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        ram_re_s    = 1'b1;
        show_pend_d = pend_eff_s;
`ifdef BRIGHTNESS_EN
        state_d     = ST_SCALE;
`else
        state_d     = ST_SEND;
`endif
      end
`ifdef BRIGHTNESS_EN
      ST_SCALE: begin
        show_pend_d = pend_eff_s;
        state_d     = ST_SEND;
      end
`endif
      ST_SEND: begin
        show_pend_d = pend_eff_s;
        if (accept_s && pix_last_q) begin
          if (pend_eff_s) begin
            front_d     = ~front_q;
            rd_ptr_d    = '0;
            show_pend_d = 1'b0;
            state_d     = ST_LOAD;
          end else begin
            state_d     = ST_IDLE;
          end
        end else if (accept_s) begin
          rd_ptr_d = rd_ptr_q + IW'(1);
          state_d  = ST_LOAD;
        end else begin
          state_d  = ST_SEND;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        show_pend_d = 1'b0;
      end
    endcase
    pix_valid_d = (state_d == ST_SEND);
    pix_last_d  = (state_d == ST_SEND) && (LW'(rd_ptr_d) == len_eff_s - LW'(1));
    busy_d      = (state_d != ST_IDLE) || show_pend_d;
  end

  // Stream FSM and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      front_q     <= 1'b0;
      show_pend_q <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      front_q     <= front_d;
      show_pend_q <= show_pend_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_last  = pix_last_q;
  assign bus.busy      = busy_q;

  ws2812_pix_dpram #(
    .DEPTH (2 * MAX_LED),
    .DW    (24)
  ) u_dpram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (commit_s),
    .waddr_i ({~front_q, idx_q}),
    .wdata_i (wdata_s),
    .re_i    (ram_re_s),
    .raddr_i ({front_q, rd_ptr_q}),
    .rdata_o (ram_rdata_s)
  );

endmodule
